csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Initiator side of the CSR read/write port. Executes Zicsr instructions (CSRRW/S/C and the immediate variants CSRRWI/SI/CI) issued by the core's execute stage.
- Each instruction is run as a sequenced read-modify-write against the CSR file: it drives the CSR file's addr/in/write_en and samples its combinational out.
- It returns the old CSR value to the pipeline through a valid/ready response handshake.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand.
- CSR_ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  instruction offered.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_funct3  in  3  Zicsr funct3. [2]=immediate form; [1:0]: 01=RW, 10=RS, 11=RC.
- req_csr_addr  in  CSR_ADDR_W  target CSR.
- req_rs1_idx  in  5  rs1 field; doubles as zimm when funct3[2]=1.
- req_rs1_val  in  XLEN  rs1 register value (ignored for immediate forms).
- csr_addr  out  CSR_ADDR_W  address to CSR file.
- csr_wdata  out  XLEN  write data to CSR file.
- csr_write_en  out  1  one-cycle write strobe to CSR file.
- csr_rdata  in  XLEN  CSR file read data (combinational from csr_addr).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  XLEN  old CSR value for rd writeback.
- rsp_illegal  out  1  instruction raised illegal-instruction.

Behaviour:
- Reset values (synchronous, rst high at posedge):
  - State goes to IDLE.
  - csr_write_en=0, rsp_valid=0, rsp_illegal=0, rsp_rdata=0, csr_addr=0, csr_wdata=0.
  - req_ready=1 in the first cycle after reset.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch funct3, csr_addr, rs1_idx, rs1_val; go to READ.
- READ:
  - csr_addr = latched address.
  - Latch old = csr_rdata.
  - src = funct3[2] ? {zeros, rs1_idx} : rs1_val.
  - new: RW -> src; RS -> old | src; RC -> old & ~src.
  - do_write = (funct3[1:0]==01) || (rs1_idx != 0).
  - Next state: WRITE if do_write and not illegal, else RESP.
- WRITE:
  - csr_write_en=1 for exactly this cycle; csr_wdata=new.
  - csr_addr is held unchanged from READ.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata=old, or 0 if illegal; rsp_illegal as computed.
  - Outputs are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE.
  - No new request is accepted in the same cycle; the earliest next accept is the following cycle.
- Latency, counted from the accept cycle (cycle 0):
  - With write: csr_write_en in cycle 2, rsp_valid from cycle 3.
  - No write: rsp_valid from cycle 2.
- Operation is non-pipelined: one instruction in flight.
- csr_write_en is never asserted outside WRITE and never for more than 1 cycle per request.
- funct3[1:0]==00 with CSR_ILLEGAL_CHECK_EN undefined: treated as a read-only access (no write), rsp_illegal=0.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. A write pending in READ is dropped; a write strobe in WRITE is deasserted at that edge.
- req_valid during non-IDLE states is ignored (req_ready=0). Request fields need not be held after accept.

Optional Feature:
- Macro CSR_ILLEGAL_CHECK_EN.
- When defined, rsp_illegal=1 and no write occurs if either:
  - funct3[1:0]==00, or
  - do_write and csr_addr[11:10]==2'b11 (read-only CSR space, e.g. mhartid 0xF14).
- On an illegal response, rsp_rdata=0.
- When undefined, rsp_illegal is tied 0. Writes to read-only addresses are issued normally, and the CSR file decides the outcome.

Test Plan:
- After reset: CSRRW 0x340 (mscratch), rs1_idx=5, rs1_val=0xDEADBEEF.
  - Expect csr_write_en in cycle 2 with wdata 0xDEADBEEF; rsp_rdata=0 in cycle 3.
  - A follow-up CSRRS x0 to 0x340 returns 0xDEADBEEF with no write_en.
- mie (0x304) holds 0x888; issue CSRRCI with zimm=0x08.
  - Expect wdata=0x880; rsp_rdata=0x888.
  - Then CSRRSI zimm=0x01: expect wdata=0x881.
- CSRRS to mstatus (0x300) with rs1_idx=0, rs1_val=0xFFFFFFFF.
  - Expect no csr_write_en; rsp_valid in cycle 2; rsp_rdata equals current mstatus.
- With CSR_ILLEGAL_CHECK_EN:
  - CSRRW to 0xF14: expect rsp_illegal=1, rsp_rdata=0, no write_en.
  - CSRRS x0 to 0xF14: expect legal, rsp_rdata=MHARTID.
  - funct3=100: expect illegal.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP.
  - rsp_valid, rsp_rdata and rsp_illegal stay stable; req_ready=0; a req_valid pulse during this time is not accepted.
  - Raise rsp_ready: back in IDLE on the next cycle.
- Reset mid-operation: assert rst during READ of a CSRRW to 0x340.
  - Expect no csr_write_en; mscratch is unchanged; rsp_valid=0 and req_ready=1 on the next cycle.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequenced read-modify-write executor for Zicsr instructions against a CSR file.
// Optional illegal-access detection (no-op funct3, writes to read-only space) when CSR_ILLEGAL_CHECK_EN is defined.
module csr_access_unit #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_csr_addr,
  input  logic [4:0]            req_rs1_idx,
  input  logic [XLEN-1:0]       req_rs1_val,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  csr_write_en,
  input  logic [XLEN-1:0]       csr_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_illegal
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state;
  logic [2:0]      f3;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_val;
  logic            do_write;
  logic            illegal;
  assign req_ready = state == IDLE;
  always_comb begin
    src      = f3[2] ? XLEN'(rs1_idx) : rs1_val;
    new_val  = f3[1:0] == 2'b01 ? src :
               f3[1:0] == 2'b10 ? csr_rdata | src : csr_rdata & ~src;
    // funct3[1:0]==00 never writes, whatever rs1 holds
    do_write = f3[1:0] == 2'b01 || (f3[1:0] != 2'b00 && rs1_idx != 5'd0);
`ifdef CSR_ILLEGAL_CHECK_EN
    illegal  = f3[1:0] == 2'b00 || (do_write && csr_addr[CSR_ADDR_W-1 -: 2] == 2'b11);
`else
    illegal  = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      f3           <= '0;
      rs1_idx      <= '0;
      rs1_val      <= '0;
      csr_addr     <= '0;
      csr_wdata    <= '0;
      csr_write_en <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3       <= req_funct3;
          rs1_idx  <= req_rs1_idx;
          rs1_val  <= req_rs1_val;
          csr_addr <= req_csr_addr;
          state    <= READ;
        end
        READ: begin
          rsp_rdata   <= illegal ? '0 : csr_rdata;
          rsp_illegal <= illegal;
          csr_wdata   <= new_val;
          if (do_write && !illegal) begin
            csr_write_en <= 1'b1;
            state        <= WRITE;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          csr_write_en <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        default: if (rsp_ready) begin
          rsp_valid   <= 1'b0;
          rsp_illegal <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed Zicsr vectors against a small CSR file model, scoreboarded responses and writes.
module tb_csr_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr_addr = '0;
  logic [4:0]  req_rs1_idx = '0;
  logic [31:0] req_rs1_val = '0;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write_en;
  logic [31:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_val(req_rs1_val),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_write_en(csr_write_en), .csr_rdata(csr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal)
  );

  // CSR file model: mhartid is read-only, unknown addresses read 0
  localparam logic [31:0] MHARTID = 32'h7;
  logic [31:0] mscratch = 32'h0;
  logic [31:0] mie      = 32'h888;
  logic [31:0] mstatus  = 32'h1800;
  always_comb
    csr_rdata = csr_addr == 12'h340 ? mscratch :
                csr_addr == 12'h304 ? mie :
                csr_addr == 12'h300 ? mstatus :
                csr_addr == 12'hF14 ? MHARTID : 32'h0;
  always @(posedge clk)
    if (csr_write_en) begin
      if (csr_addr == 12'h340) mscratch <= csr_wdata;
      if (csr_addr == 12'h304) mie      <= csr_wdata;
      if (csr_addr == 12'h300) mstatus  <= csr_wdata;
    end

  int cyc = 0;
  int acc_count = 0;
  int n_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (req_valid && req_ready) acc_count <= acc_count + 1;

  typedef struct {logic [31:0] rdata; logic ill; int at;} rsp_t;
  typedef struct {logic [11:0] addr; logic [31:0] wdata; int at;} wr_t;
  rsp_t rq[$];
  wr_t  wq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s", name);
  endtask

  // monitor: compares every write strobe and every response against the queued expectations
  logic        seen = 1'b0;
  logic [31:0] h_rdata;
  logic        h_ill;
  always @(negedge clk) begin
    wr_t  w;
    rsp_t r;
    if (csr_write_en === 1'b1) begin
      if (wq.size() == 0) flag("unexpected csr_write_en");
      else begin
        w = wq.pop_front();
        check("wr_addr", 32'(csr_addr), 32'(w.addr));
        check("wr_data", csr_wdata, w.wdata);
        check("wr_cycle", cyc, w.at);
      end
    end
    if (rsp_valid === 1'b1) begin
      if (!seen) begin
        seen    = 1'b1;
        h_rdata = rsp_rdata;
        h_ill   = rsp_illegal;
        if (rq.size() == 0) flag("unexpected rsp_valid");
        else begin
          r = rq[0];
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_illegal", 32'(rsp_illegal), 32'(r.ill));
          check("rsp_cycle", cyc, r.at);
        end
      end else begin
        check("hold_rdata", rsp_rdata, h_rdata);
        check("hold_illegal", 32'(rsp_illegal), 32'(h_ill));
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      if (rsp_ready) begin
        seen = 1'b0;
        if (rq.size() != 0) void'(rq.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) flag("timeout waiting req_ready");
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] val, input logic [31:0] exp_rd, input logic exp_ill,
                       input logic wr, input logic [31:0] wd);
    wait_ready();
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_addr = a;
    req_rs1_idx  = idx;
    req_rs1_val  = val;
    n_acc++;
    rq.push_back('{exp_rd, exp_ill, cyc + (wr ? 3 : 2)});
    if (wr) wq.push_back('{a, wd, cyc + 2});
    @(negedge clk);
    req_valid    = 1'b0;
    req_funct3   = 3'b011;
    req_csr_addr = 12'h300;
    req_rs1_idx  = 5'd31;
    req_rs1_val  = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      flag("timeout waiting response");
      rq.delete();
      wq.delete();
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                     input logic [31:0] val, input logic [31:0] exp_rd, input logic exp_ill,
                     input logic wr, input logic [31:0] wd);
    issue(f3, a, idx, val, exp_rd, exp_ill, wr, wd);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_write_en", 32'(csr_write_en), 32'd0);
    check("rst_csr_addr", 32'(csr_addr), 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    rst = 1'b0;
    // CSRRW mscratch, then CSRRS x0 readback
    run(3'b001, 12'h340, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    run(3'b010, 12'h340, 5'd0, 32'h55, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    // reset while READ of a CSRRW drops the write
    wait_ready();
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340;
    req_rs1_idx = 5'd5; req_rs1_val = 32'h12345678;
    n_acc++;
    @(negedge clk);
    req_valid = 1'b0;
    check("read_csr_addr", 32'(csr_addr), 32'h340);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_write_en", 32'(csr_write_en), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_csr_addr", 32'(csr_addr), 32'd0);
    @(negedge clk);
    check("midrst_mscratch", mscratch, 32'hDEADBEEF);
    run(3'b010, 12'h340, 5'd0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    // immediate forms on mie
    run(3'b111, 12'h304, 5'h08, 32'hFFFFFFFF, 32'h888, 1'b0, 1'b1, 32'h880);
    run(3'b110, 12'h304, 5'h01, 32'h0, 32'h880, 1'b0, 1'b1, 32'h881);
    // rs1=x0 set on mstatus: no write, two-cycle latency
    run(3'b010, 12'h300, 5'd0, 32'hFFFFFFFF, 32'h1800, 1'b0, 1'b0, 32'h0);
    run(3'b011, 12'h300, 5'd2, 32'h800, 32'h1800, 1'b0, 1'b1, 32'h1000);
    run(3'b101, 12'h340, 5'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
    run(3'b010, 12'h340, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    // backpressure: rsp_ready low for four RESP cycles, stray req_valid ignored
    rsp_ready = 1'b0;
    issue(3'b110, 12'h304, 5'h10, 32'h0, 32'h881, 1'b0, 1'b1, 32'h891);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h340; req_rs1_val = 32'hBAD;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_req_ready_after", 32'(req_ready), 32'd1);
    check("bp_rsp_valid_after", 32'(rsp_valid), 32'd0);
    wait_done();
`ifdef CSR_ILLEGAL_CHECK_EN
    run(3'b001, 12'hF14, 5'd5, 32'h5, 32'h0, 1'b1, 1'b0, 32'h0);
    run(3'b010, 12'hF14, 5'd0, 32'h0, MHARTID, 1'b0, 1'b0, 32'h0);
    run(3'b100, 12'h304, 5'd3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
`else
    run(3'b001, 12'hF14, 5'd5, 32'h5, MHARTID, 1'b0, 1'b1, 32'h5);
    run(3'b010, 12'hF14, 5'd0, 32'h0, MHARTID, 1'b0, 1'b0, 32'h0);
    run(3'b100, 12'h304, 5'd3, 32'h0, 32'h891, 1'b0, 1'b0, 32'h0);
`endif
    check("mie_final", mie, 32'h891);
    check("accept_count", acc_count, n_acc);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
